// File: rtl/input_capture_if.sv
// Control, event and capture-handshake signals of the input capture block.
// The master side configures the block and consumes captures; the slave side is the block.
interface input_capture_if;
  logic        en;
  logic        start;
  logic        one_shot;
  logic [1:0]  edge_sel;
  logic [15:0] prescaler;
  logic        evt_in;
  logic        cap_ready;
  logic        clr_ovr;
  logic [15:0] cap_value;
  logic        cap_sat;
  logic        cap_valid;
  logic        overrun;
  logic        busy;

  modport master (
    output en, start, one_shot, edge_sel, prescaler, evt_in, cap_ready, clr_ovr,
    input  cap_value, cap_sat, cap_valid, overrun, busy
  );

  modport slave (
    input  en, start, one_shot, edge_sel, prescaler, evt_in, cap_ready, clr_ovr,
    output cap_value, cap_sat, cap_valid, overrun, busy
  );
endinterface

// File: rtl/input_capture.sv
// Measures the interval between qualified edges of an asynchronous event in prescaled
// clock units and hands each result to a consumer over a valid/ready handshake.
module input_capture (
  input  logic           clk,
  input  logic           rst,
  input_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t      state;
  logic        s1, s2, s3;
  logic [15:0] pcnt;
  logic [15:0] count;
  logic        sat;

  logic        rise, fall, evt_edge;
  logic        tick;
  logic        count_max;
  logic        capture;
  logic [15:0] cap_next;
  logic        cap_next_sat;

  // s1/s2 resynchronise evt_in; s3 holds the previous synchronised level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes s1->s2->s3 a shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.evt_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // NOTE: every path assigns evt_edge, so this stays combinational with no latch.
  always_comb begin
    case (bus.edge_sel)
      2'b01:   evt_edge = fall;
      2'b10:   evt_edge = rise | fall;
      default: evt_edge = rise;
    endcase
  end

  assign tick      = (state != IDLE) && (pcnt == bus.prescaler);
  assign count_max = (count == 16'hFFFF);

  // Interval including a tick that lands on the capture cycle, clamped at 0xFFFF.
  assign cap_next     = (tick && !count_max) ? count + 16'd1 : count;
  assign cap_next_sat = sat | (tick & count_max);

  assign capture = bus.en && !bus.start && (state == MEASURE) && evt_edge;

  // NOTE: the clear/transition branches below come after the counter advance;
  // of several non-blocking writes to one flop in a block, the last one wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pcnt  <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else begin
      if (tick) begin
        pcnt <= '0;
        if (count_max) sat   <= 1'b1;
        else           count <= count + 16'd1;
      end else if (state != IDLE) begin
        pcnt <= pcnt + 16'd1;
      end

      if (!bus.en) begin
        state <= IDLE;
        pcnt  <= '0;
        count <= '0;
        sat   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            pcnt  <= '0;
            count <= '0;
            sat   <= 1'b0;
            if (bus.start) state <= ARM;
          end
          ARM, MEASURE: begin
            if (bus.start || evt_edge) begin
              pcnt  <= '0;
              count <= '0;
              sat   <= 1'b0;
            end
            if (bus.start)                                  state <= ARM;
            else if (evt_edge && state == MEASURE && bus.one_shot) state <= IDLE;
            else if (evt_edge)                              state <= MEASURE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // busy is a registered decode of the state register.
  always_ff @(posedge clk) begin
    if (rst) bus.busy <= 1'b0;
    else     bus.busy <= (state != IDLE);
  end

  // A held capture that nobody has accepted blocks new ones; the dropped result is
  // flagged in overrun, and a fresh drop outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cap_value <= '0;
      bus.cap_sat   <= 1'b0;
      bus.cap_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (capture && (!bus.cap_valid || bus.cap_ready)) begin
        bus.cap_value <= cap_next;
        bus.cap_sat   <= cap_next_sat;
        bus.cap_valid <= 1'b1;
      end else if (bus.cap_valid && bus.cap_ready) begin
        bus.cap_valid <= 1'b0;
      end

      if (capture && bus.cap_valid && !bus.cap_ready) bus.overrun <= 1'b1;
      else if (bus.clr_ovr)                           bus.overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_capture.sv
// Self-checking bench for input_capture: directed scenarios plus randomized edge
// streams scored against an interval model computed from toggle times.
`timescale 1ns/1ps
module tb_input_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  input_capture_if bus ();

  input_capture dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int   gap_q[$];
  int   exp_v[$];
  logic exp_s[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input int pre, input logic [1:0] es, input logic os, input logic rdy);
    bus.en        = 1'b0;
    bus.start     = 1'b0;
    bus.evt_in    = 1'b0;
    bus.clr_ovr   = 1'b0;
    bus.cap_ready = rdy;
    bus.prescaler = 16'(pre);
    bus.edge_sel  = es;
    bus.one_shot  = os;
    step(4);
  endtask

  task automatic arm();
    bus.en    = 1'b1;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  // One clock: score any accepted capture at the falling edge, then advance.
  task automatic cycle_mon(input string name);
    int   v;
    logic s;
    @(negedge clk);
    if (bus.cap_valid && bus.cap_ready) begin
      n_assert++;
      if (exp_v.size() == 0) begin
        n_fail++;
        $display("FAIL %s unexpected capture: got value %0d, required no capture", name, bus.cap_value);
      end else begin
        v = exp_v.pop_front();
        s = exp_s.pop_front();
        if (bus.cap_value !== 16'(v) || bus.cap_sat !== s) begin
          n_fail++;
          $display("FAIL %s capture: got value %0d sat %b, required value %0d sat %b",
                   name, bus.cap_value, bus.cap_sat, v, s);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // gap_q holds clock counts between successive evt_in toggles, starting from level 0.
  task automatic run_stream(input string name, input int pre, input logic [1:0] es, input logic os);
    int   t;
    logic lvl;
    int   det[$];
    int   units;
    drive_idle(pre, es, os, 1'b1);
    exp_v.delete();
    exp_s.delete();
    t   = 0;
    lvl = 1'b0;
    foreach (gap_q[i]) begin
      t  += gap_q[i];
      lvl = ~lvl;
      if (es == 2'b10 || (es == 2'b01 ? !lvl : lvl)) det.push_back(t);
    end
    for (int i = 1; i < det.size(); i++) begin
      if (os && i > 1) break;
      units = (det[i] - det[i-1]) / (pre + 1);
      exp_v.push_back(units > 65535 ? 65535 : units);
      exp_s.push_back(units > 65535);
    end
    arm();
    foreach (gap_q[i]) begin
      repeat (gap_q[i]) cycle_mon(name);
      bus.evt_in = ~bus.evt_in;
    end
    repeat (6) cycle_mon(name);
    n_assert++;
    if (exp_v.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing captures: got %0d outstanding, required 0", name, exp_v.size());
    end
    n_assert++;
    if (bus.busy !== !os) begin
      n_fail++;
      $display("FAIL %s final busy: got %b, required %b", name, bus.busy, !os);
    end
  endtask

  task automatic test_reset();
    drive_idle(0, 2'b00, 1'b0, 1'b0);
    n_assert++;
    if ({bus.cap_value, bus.cap_sat, bus.cap_valid, bus.overrun, bus.busy} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset outputs: got value %h sat %b valid %b ovr %b busy %b, required all zero",
               bus.cap_value, bus.cap_sat, bus.cap_valid, bus.overrun, bus.busy);
    end
    rst = 1'b0;
    step(2);
    n_assert++;
    if (bus.busy !== 1'b0 || bus.cap_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset idle: got busy %b valid %b, required 0 0", bus.busy, bus.cap_valid);
    end
  endtask

  task automatic test_prescaled_stream();
    gap_q.delete();
    gap_q.push_back(5);
    repeat (8) gap_q.push_back(100);
    run_stream("prescaled_stream", 9, 2'b00, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      gap_q.delete();
      repeat (8) gap_q.push_back(int'($urandom_range(120, 3)));
      run_stream($sformatf("random_%0d", it), int'($urandom_range(5, 0)),
                 2'($urandom_range(3, 0)), 1'b0);
    end
  endtask

  task automatic test_one_shot();
    gap_q = '{5, 37, 30, 30, 25};
    run_stream("one_shot_both", 0, 2'b10, 1'b1);
  endtask

  task automatic test_saturation();
    gap_q = '{5, 70000, 20};
    run_stream("saturation", 0, 2'b10, 1'b1);
  endtask

  task automatic test_overrun();
    drive_idle(0, 2'b10, 1'b0, 1'b0);
    arm();
    bus.evt_in = 1'b1;
    step(10);
    bus.evt_in = 1'b0;
    step(2);
    n_assert++;
    if (bus.cap_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency early: got valid %b two edges after sampling, required 0", bus.cap_valid);
    end
    step(1);
    n_assert++;
    if (bus.cap_valid !== 1'b1 || bus.cap_value !== 16'd10) begin
      n_fail++;
      $display("FAIL latency capture: got valid %b value %0d, required 1 10", bus.cap_valid, bus.cap_value);
    end
    step(17);
    bus.evt_in = 1'b1;
    step(4);
    n_assert++;
    if (bus.cap_valid !== 1'b1 || bus.cap_value !== 16'd10 || bus.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun drop: got valid %b value %0d ovr %b, required 1 10 1",
               bus.cap_valid, bus.cap_value, bus.overrun);
    end
    bus.clr_ovr = 1'b1;
    step(1);
    bus.clr_ovr = 1'b0;
    n_assert++;
    if (bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun clear: got %b, required 0", bus.overrun);
    end
    bus.evt_in = 1'b0;
    step(2);
    bus.clr_ovr = 1'b1;
    step(1);
    bus.clr_ovr = 1'b0;
    n_assert++;
    if (bus.overrun !== 1'b1 || bus.cap_value !== 16'd10) begin
      n_fail++;
      $display("FAIL overrun vs clear: got ovr %b value %0d, required 1 10", bus.overrun, bus.cap_value);
    end
    bus.cap_ready = 1'b1;
    step(1);
    bus.cap_ready = 1'b0;
    n_assert++;
    if (bus.cap_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake release: got valid %b, required 0", bus.cap_valid);
    end
  endtask

  task automatic test_abort();
    drive_idle(0, 2'b10, 1'b0, 1'b1);
    arm();
    bus.evt_in = 1'b1;
    step(6);
    n_assert++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort setup busy: got %b, required 1", bus.busy);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_assert++;
    if ({bus.cap_value, bus.cap_sat, bus.cap_valid, bus.overrun, bus.busy} !== 20'h0) begin
      n_fail++;
      $display("FAIL abort reset outputs: got value %h sat %b valid %b ovr %b busy %b, required all zero",
               bus.cap_value, bus.cap_sat, bus.cap_valid, bus.overrun, bus.busy);
    end
    bus.evt_in = 1'b0;
    step(6);
    n_assert++;
    if (bus.cap_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort after edge: got valid %b busy %b, required 0 0", bus.cap_valid, bus.busy);
    end
  endtask

  task automatic test_enable_drop();
    drive_idle(1, 2'b10, 1'b0, 1'b0);
    arm();
    bus.evt_in = 1'b1;
    step(12);
    bus.evt_in = 1'b0;
    step(5);
    n_assert++;
    if (bus.cap_valid !== 1'b1 || bus.cap_value !== 16'd6 || bus.cap_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL prescaled capture: got valid %b value %0d sat %b, required 1 6 0",
               bus.cap_valid, bus.cap_value, bus.cap_sat);
    end
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(1);
    n_assert++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm busy: got %b, required 1", bus.busy);
    end
    bus.en = 1'b0;
    step(2);
    n_assert++;
    if (bus.busy !== 1'b0 || bus.cap_valid !== 1'b1 || bus.cap_value !== 16'd6) begin
      n_fail++;
      $display("FAIL enable drop: got busy %b valid %b value %0d, required 0 1 6",
               bus.busy, bus.cap_valid, bus.cap_value);
    end
    bus.evt_in = 1'b1;
    step(6);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(1);
    n_assert++;
    if (bus.busy !== 1'b0 || bus.cap_value !== 16'd6 || bus.overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled start ignored: got busy %b value %0d ovr %b, required 0 6 0",
               bus.busy, bus.cap_value, bus.overrun);
    end
    bus.cap_ready = 1'b1;
    step(1);
    bus.cap_ready = 1'b0;
    n_assert++;
    if (bus.cap_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL disabled handshake: got valid %b, required 0", bus.cap_valid);
    end
  endtask

  initial begin
    test_reset();
    test_prescaled_stream();
    test_random();
    test_one_shot();
    test_saturation();
    test_overrun();
    test_abort();
    test_enable_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
